// File: rtl/crt1_pkg.sv
// Shared constants and types for the crt1 truth-table cell.
package crt1_pkg;

  localparam int unsigned MT_W = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [MT_W-1:0] CRT1_TT_MAJORITY = 8'hE8;
  localparam logic [MT_W-1:0] CRT1_TT_PARITY   = 8'h96;

  typedef logic [MT_W-1:0] minterm_t;

endpackage

// File: rtl/crt1_lut.sv
// Combinational minterm decode and truth-table select for {a,b,c}.
module crt1_lut
  import crt1_pkg::*;
#(
  parameter logic [MT_W-1:0] TRUTH_TABLE = CRT1_TT_MAJORITY
) (
  input  logic           a,
  input  logic           b,
  input  logic           c,
  output logic           y_c,
  output logic [MT_W-1:0] minterm_c
);

  logic [IDX_W-1:0] m;

  assign m         = {a, b, c};
  assign minterm_c = minterm_t'(1) << m;
  assign y_c       = TRUTH_TABLE[m];

endmodule

// File: rtl/crt1.sv
// Registered truth-table cell with one-hot minterm and saturating y-change counter.
module crt1
  import crt1_pkg::*;
#(
  parameter logic [MT_W-1:0] TRUTH_TABLE = CRT1_TT_MAJORITY,
  parameter int              CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic [MT_W-1:0]  minterm,
  output logic [CNT_W-1:0] y_toggles
);

  logic     y_c;
  minterm_t minterm_c;

  crt1_lut #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut (
    .a        (a),
    .b        (b),
    .c        (c),
    .y_c      (y_c),
    .minterm_c(minterm_c)
  );

  // Counter compares the incoming y against the held one, so the first
  // edge after reset counts a 0->1 change like any other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= 1'b0;
      minterm   <= '0;
      y_toggles <= '0;
    end else begin
      y       <= y_c;
      minterm <= minterm_c;
      if ((y_c != y) && (y_toggles != {CNT_W{1'b1}}))
        y_toggles <= y_toggles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_crt1.sv
// Self-checking bench for crt1: majority, parity and narrow-counter instances.
module tb_crt1;
  import crt1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c;

  logic       y0, y1, y2;
  logic [7:0] min0, min1, min2;
  logic [7:0] tog0, tog1;
  logic [1:0] tog2;

  always #5 clk = ~clk;

  crt1 u_maj (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .y(y0), .minterm(min0), .y_toggles(tog0)
  );

  crt1 #(.TRUTH_TABLE(8'h96)) u_par (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .y(y1), .minterm(min1), .y_toggles(tog1)
  );

  crt1 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .y(y2), .minterm(min2), .y_toggles(tog2)
  );

  typedef struct {
    logic [2:0] m;
    logic       exp_maj;
    logic       exp_par;
    logic [7:0] exp_min;
  } vec_t;

  typedef struct {
    logic [2:0] y;
    logic [7:0] minterm;
    int         cnt0;
    int         cnt1;
    int         cnt2;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tt [3];
  logic       model_y [3];
  int         model_cnt [3];
  int         cnt_max [3];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      model_y[i]   = 1'b0;
      model_cnt[i] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y_maj"},   int'(y0),   0);
    check({tag, "_y_par"},   int'(y1),   0);
    check({tag, "_min"},     int'(min0), 0);
    check({tag, "_tog_maj"}, int'(tog0), 0);
    check({tag, "_tog_sat"}, int'(tog2), 0);
  endtask

  // Drive one minterm at the falling edge, queue the expectation, check after the next rise.
  task automatic drive(input logic [2:0] m, input bit release_rst);
    exp_t       e;
    exp_t       got;
    logic [7:0] row;
    logic       ny;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    {a, b, c} = m;
    for (int i = 0; i < 3; i++) begin
      row = tt[i];
      ny  = row[m];
      if (ny != model_y[i] && model_cnt[i] < cnt_max[i]) model_cnt[i]++;
      model_y[i] = ny;
    end
    e.y       = {model_y[2], model_y[1], model_y[0]};
    e.minterm = 8'h01 << m;
    e.cnt0    = model_cnt[0];
    e.cnt1    = model_cnt[1];
    e.cnt2    = model_cnt[2];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("y_maj",   int'(y0),   int'(got.y[0]));
    check("y_par",   int'(y1),   int'(got.y[1]));
    check("y_sat",   int'(y2),   int'(got.y[2]));
    check("minterm", int'(min0), int'(got.minterm));
    check("min_par", int'(min1), int'(got.minterm));
    check("tog_maj", int'(tog0), got.cnt0);
    check("tog_par", int'(tog1), got.cnt1);
    check("tog_sat", int'(tog2), got.cnt2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3'd0, 1'b0, 1'b0, 8'h01};
    vecs[1] = '{3'd1, 1'b0, 1'b1, 8'h02};
    vecs[2] = '{3'd2, 1'b0, 1'b1, 8'h04};
    vecs[3] = '{3'd3, 1'b1, 1'b0, 8'h08};
    vecs[4] = '{3'd4, 1'b0, 1'b1, 8'h10};
    vecs[5] = '{3'd5, 1'b1, 1'b0, 8'h20};
    vecs[6] = '{3'd6, 1'b1, 1'b0, 8'h40};
    vecs[7] = '{3'd7, 1'b1, 1'b1, 8'h80};
    tt[0] = 8'hE8; tt[1] = 8'h96; tt[2] = 8'hE8;
    cnt_max[0] = 255; cnt_max[1] = 255; cnt_max[2] = 3;
    model_reset();

    // Reset held across edges with nonzero inputs.
    rst_n = 1'b0;
    {a, b, c} = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    // Table sweep straight out of reset; first edge loads the inputs.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].m, i == 0);
      check("tab_y_maj", int'(y0),   int'(vecs[i].exp_maj));
      check("tab_y_par", int'(y1),   int'(vecs[i].exp_par));
      check("tab_min",   int'(min0), int'(vecs[i].exp_min));
    end
    check("sweep_tog_maj", int'(tog0), 3);
    check("sweep_tog_par", int'(tog1), 5);

    // Hold 3'b110: y and minterm steady, no counting.
    for (int i = 0; i < 5; i++) begin
      drive(3'b110, 1'b0);
      check("hold_y",   int'(y0),   1);
      check("hold_min", int'(min0), 8'h40);
      check("hold_tog", int'(tog0), 3);
    end

    // Asynchronous reset between edges, mid-sweep.
    drive(3'd2, 1'b0);
    drive(3'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("async_hold");
    model_reset();
    drive(3'd5, 1'b1);
    check("post_rst_y",   int'(y0),   1);
    check("post_rst_tog", int'(tog0), 1);
    drive(3'd6, 1'b0);
    drive(3'd1, 1'b0);

    // Narrow counter saturates at 3 and holds.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 10; i++)
      drive((i % 2 == 0) ? 3'd0 : 3'd7, i == 0);
    check("sat_tog_final", int'(tog2), 3);
    check("sat_tog_wide",  int'(tog0), 9);
    drive(3'd7, 1'b0);
    check("sat_tog_hold",  int'(tog2), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
